epg: RTL and testbench
======================

# epg

Ethernet packet generator: the transmit-side counterpart of the packet detector. On a start request it emits a complete Ethernet frame as a byte stream on `data`/`control`: preamble, SFD, destination address, source address, type/length, payload, zero padding and CRC-32 FCS. It then holds an inter-frame gap before it can accept the next start. Its `data`/`control` outputs drive the detector's `data`/`control` inputs directly, for loopback testing and for frame generation.

## Interface
- `IFG_CYCLES`, 12: idle cycles (`control`=0) after the last FCS byte before a new start is accepted.
- `MIN_PAYLOAD`, 46: minimum payload bytes; shorter payloads are zero-padded up to this.
- `MAX_PAYLOAD`, 1500: largest accepted `payload_len`.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to send a frame; sampled only in IDLE.
- `dst_addr`  in  48  destination MAC; sent MSB byte first.
- `src_addr`  in  48  source MAC; sent MSB byte first.
- `type_length`  in  16  type/length field; sent MSB byte first.
- `payload_len`  in  11  number of payload bytes supplied by the source.
- `payload_data`  in  8  payload byte; show-ahead, valid whenever `payload_rd` is high.
- `payload_rd`  out  1  combinational pop strobe; `payload_data` is consumed this cycle.
- `data`  out  8  registered frame byte.
- `control`  out  1  registered; high exactly on cycles that carry a frame byte.
- `busy`  out  1  high from the first preamble cycle through the last IFG cycle.
- `done`  out  1  one-cycle pulse in the first IFG cycle.
- `len_error`  out  1  one-cycle pulse when a start is rejected.
- `tx_packet_counter`  out  4  count of completed frames; wraps 15→0.

## Operation
- States: IDLE, PREAMBLE (7 bytes of 0x55), SFD (0xD5), DST (6), SRC (6), TYPE (2), PAYLOAD (`payload_len`), PAD (`MIN_PAYLOAD`−`payload_len` bytes of 0x00, skipped if ≤0), FCS (4), GAP (`IFG_CYCLES`).
- On `start` in IDLE:
  - `dst_addr`, `src_addr`, `type_length` and `payload_len` are latched.
  - Later changes to these inputs are ignored until IDLE is re-entered.
- `payload_len`=0 or >`MAX_PAYLOAD`: the start is rejected. `len_error` pulses next cycle, the block stays in IDLE and emits no bytes.
- `payload_len`=0 with `MIN_PAYLOAD`>0 is rejected as well; it is not treated as all-pad.
- `payload_rd` is asserted once per PAYLOAD byte, in the cycle before that byte appears on `data`. It is never asserted in any other state. The source must not underflow; the block does not check for underflow.
- A byte counter (11 bits) sequences each field. It reloads on every state transition.
- CRC-32:
  - Covers DST through PAD inclusive.
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, processed LSB-first per byte.
  - The FCS is the ones' complement of the register, sent least-significant byte first.
  - Preamble and SFD are excluded from the CRC.
- `tx_packet_counter` increments by 1 (mod 16) in the same cycle `done` pulses.
- `start` during any non-IDLE state is ignored; requests are not queued.
- Reset (asynchronous, any state):
  - State → IDLE.
  - `data`=0x00, `control`=0, `busy`=0, `done`=0, `len_error`=0, `tx_packet_counter`=0, CRC=0xFFFFFFFF.
  - A frame in flight is truncated; `control` drops immediately.

## Timing
- `start` sampled high in cycle t (IDLE, length valid): the first 0x55 appears on `data` with `control`=1 at t+1.
- SFD at t+8; first DST byte at t+9.
- Frame occupies 8+14+max(`payload_len`,`MIN_PAYLOAD`)+4 consecutive cycles with `control`=1 and no bubbles.
- `done` and the counter update occur the cycle after the last FCS byte. `control`=0 from that cycle onward.
- GAP lasts `IFG_CYCLES` cycles. IDLE is re-entered afterwards, and `start` is accepted in the first IDLE cycle.
- Back-to-back throughput: one frame per frame-length + `IFG_CYCLES` + 1 cycles.
- `data` holds 0x00 whenever `control`=0.

## Test plan
- Minimum frame:
  - Stimulus: `payload_len`=46, payload 0x00..0x2D, dst=0xFFFFFFFFFFFF, src=0x001122334455, type=0x0800.
  - Required: 72 bytes with `control`=1.
  - Required: bytes 0–6 = 0x55, byte 7 = 0xD5, bytes 8–13 = 0xFF, bytes 14–19 = 0x00..0x55.
  - Required: running CRC over bytes 8–71 (un-inverted register) = residue 0xDEBB20E3.
  - Required: `done` at t+73; counter = 1.
- Short payload:
  - Stimulus: `payload_len`=10.
  - Required: exactly 10 `payload_rd` pulses, then 36 bytes of 0x00, then FCS; 72 bytes total.
- Rejected length:
  - Stimulus: `payload_len`=1501, then separately `payload_len`=0.
  - Required: `len_error` pulses for each; `control` stays 0; counter unchanged.
- Back-to-back and wrap:
  - Stimulus: `start` held high for 16 frames of `payload_len`=46.
  - Required: exactly 12 idle cycles plus 1 IDLE cycle between frames; counter goes 1..15, then 0.
- Reset mid-frame:
  - Stimulus: assert `reset` during PAYLOAD.
  - Required: `control`=0 immediately; all outputs at reset values; the next start produces a full correct frame.
- Loopback:
  - Stimulus: drive the packet detector from `data`/`control`.
  - Required: all detector valid flags asserted and its `valid_packet_counter` matches `tx_packet_counter`.

Source files
------------

// File: rtl/epg_if.sv
// epg_if: frame request, payload source and byte-stream outputs of the packet generator
interface epg_if;
  logic        start;
  logic [47:0] dst_addr;
  logic [47:0] src_addr;
  logic [15:0] type_length;
  logic [10:0] payload_len;
  logic [7:0]  payload_data;
  logic        payload_rd;
  logic [7:0]  data;
  logic        control;
  logic        busy;
  logic        done;
  logic        len_error;
  logic [3:0]  tx_packet_counter;
  modport master (
    output start, dst_addr, src_addr, type_length, payload_len, payload_data,
    input  payload_rd, data, control, busy, done, len_error, tx_packet_counter
  );
  modport slave (
    input  start, dst_addr, src_addr, type_length, payload_len, payload_data,
    output payload_rd, data, control, busy, done, len_error, tx_packet_counter
  );
endinterface

// File: rtl/epg.sv
// epg: emits preamble, SFD, header, payload, zero pad and CRC-32 FCS, then holds an inter-frame gap
module epg #(
  parameter int IFG_CYCLES  = 12,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input logic  clk,
  input logic  rst,
  epg_if.slave bus
);
  typedef enum logic [3:0] {S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYP, S_PAY, S_PAD, S_FCS, S_GAP} state_t;
  state_t       r_state, w_next;
  logic [10:0]  r_cnt, r_len, w_cnt1, w_flen;
  logic [111:0] r_hdr;
  logic [31:0]  r_crc, w_fcs;
  logic [7:0]   r_data, w_byte;
  logic [3:0]   r_pkt_cnt;
  logic         r_control, r_busy, r_done, r_len_error;
  logic         w_ok, w_acc, w_last, w_fin;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  assign w_ok   = bus.payload_len != 11'd0 && bus.payload_len <= 11'(MAX_PAYLOAD);
  assign w_acc  = r_state == S_IDLE && bus.start && w_ok;
  assign w_cnt1 = r_cnt + 11'd1;
  assign w_flen = r_state == S_PRE ? 11'd7 :
                  r_state == S_SFD ? 11'd1 :
                  (r_state == S_DST || r_state == S_SRC) ? 11'd6 :
                  r_state == S_TYP ? 11'd2 :
                  r_state == S_PAY ? r_len :
                  r_state == S_PAD ? 11'(MIN_PAYLOAD) - r_len :
                  r_state == S_FCS ? 11'd4 :
                  r_state == S_GAP ? 11'(IFG_CYCLES) : 11'd0;
  assign w_last = w_cnt1 == w_flen;
  assign w_fin  = r_state == S_FCS && w_last;
  // FCS bytes go out least-significant first; the register already holds every covered byte
  assign w_fcs  = ~r_crc >> {(r_state == S_FCS ? w_cnt1[1:0] : 2'd0), 3'd0};
  assign w_byte = w_next == S_PRE ? 8'h55 :
                  w_next == S_SFD ? 8'hD5 :
                  (w_next inside {S_DST, S_SRC, S_TYP}) ? r_hdr[111:104] :
                  w_next == S_PAY ? bus.payload_data :
                  w_next == S_FCS ? w_fcs[7:0] : 8'h00;
  assign bus.payload_rd        = w_next == S_PAY;
  assign bus.data              = r_data;
  assign bus.control           = r_control;
  assign bus.busy              = r_busy;
  assign bus.done              = r_done;
  assign bus.len_error         = r_len_error;
  assign bus.tx_packet_counter = r_pkt_cnt;

  // field sequencing: advance to the next field once its byte count is exhausted
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE) w_next = w_acc ? S_PRE : S_IDLE;
    else if (w_last)
      case (r_state)
        S_PRE:   w_next = S_SFD;
        S_SFD:   w_next = S_DST;
        S_DST:   w_next = S_SRC;
        S_SRC:   w_next = S_TYP;
        S_TYP:   w_next = S_PAY;
        S_PAY:   w_next = r_len < 11'(MIN_PAYLOAD) ? S_PAD : S_FCS;
        S_PAD:   w_next = S_FCS;
        S_FCS:   w_next = S_GAP;
        default: w_next = S_IDLE;
      endcase
  end

  // state, header shifter, running CRC and registered stream outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_hdr       <= '0;
      r_crc       <= '1;
      r_data      <= '0;
      r_control   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_len_error <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_next == r_state ? w_cnt1 : '0;
      if (w_acc) begin
        r_hdr <= {bus.dst_addr, bus.src_addr, bus.type_length};
        r_len <= bus.payload_len;
      end else if (w_next inside {S_DST, S_SRC, S_TYP}) r_hdr <= r_hdr << 8;
      r_crc       <= r_state == S_IDLE ? '1 :
                     (w_next inside {S_DST, S_SRC, S_TYP, S_PAY, S_PAD}) ? crc8(r_crc, w_byte) : r_crc;
      r_data      <= w_byte;
      r_control   <= !(w_next inside {S_IDLE, S_GAP});
      r_busy      <= w_next != S_IDLE;
      r_done      <= w_fin;
      r_len_error <= r_state == S_IDLE && bus.start && !w_ok;
      if (w_fin) r_pkt_cnt <= r_pkt_cnt + 4'd1;
    end
endmodule

// File: tb/tb_epg.sv
// tb_epg: frame generator bench with table vectors, random frames and a byte-level frame model
module tb_epg;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  epg_if bus();
  epg dut (.clk(clk), .rst(rst), .bus(bus));

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [10:0] len; bit err; int nb; } vec_t;
  logic [7:0] pay [0:1499];
  int pidx = 0, n_chk = 0, n_pass = 0;
  bit rd_prev = 1'b0;
  bq_t got;
  assign bus.payload_data = pay[pidx];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rd_prev) pidx = (pidx + 1) % 1500;
    rd_prev = bus.payload_rd;
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : (r >> 1);
    return r;
  endfunction

  function automatic bq_t build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] ty, input int len);
    bq_t q;
    logic [31:0] c;
    c = '1;
    repeat (7) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) q.push_back(d[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(s[i*8 +: 8]);
    q.push_back(ty[15:8]);
    q.push_back(ty[7:0]);
    for (int i = 0; i < len; i++) q.push_back(pay[i]);
    for (int i = len; i < 46; i++) q.push_back(8'h00);
    for (int i = 8; i < q.size(); i++) c = crc_upd(c, q[i]);
    for (int i = 0; i < 4; i++) q.push_back(8'(~c >> (8 * i)));
    return q;
  endfunction

  task automatic run_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] ty,
                           input logic [10:0] len, input bit inc, input bit noise,
                           output int nb, output bit err);
    bq_t exp;
    int rds = 0, bad = 0, errs = 0, gap = 0;
    logic [31:0] res = '1;
    logic [3:0] c0;
    bit ok;
    ok = len != 11'd0 && len <= 11'd1500;
    for (int i = 0; i < 1500; i++) pay[i] = inc ? 8'(i) : 8'($urandom);
    pidx = 0;
    rd_prev = 1'b0;
    c0 = bus.tx_packet_counter;
    bus.dst_addr = d; bus.src_addr = s; bus.type_length = ty; bus.payload_len = len; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.dst_addr = 48'({$urandom, $urandom}); bus.src_addr = 48'({$urandom, $urandom});
    bus.type_length = 16'($urandom); bus.payload_len = 11'($urandom);
    err = bus.len_error;
    got = {};
    nb = 0;
    if (!ok) begin
      check("rej_ctl", 64'(bus.control), 64'(0));
      check("rej_busy", 64'(bus.busy), 64'(0));
      step();
      check("rej_pulse_once", 64'(bus.len_error), 64'(0));
      check("rej_cnt", 64'(bus.tx_packet_counter), 64'(c0));
      return;
    end
    exp = build(d, s, ty, int'(len));
    for (int k = 0; k < 1600 && bus.control; k++) begin
      got.push_back(bus.data);
      rds += int'(bus.payload_rd);
      errs += int'(bus.len_error);
      if (noise) bus.start = 1'($urandom);
      step();
    end
    bus.start = 1'b0;
    nb = got.size();
    for (int i = 0; i < nb && i < exp.size(); i++) if (got[i] !== exp[i]) bad++;
    for (int i = 8; i < nb; i++) res = crc_upd(res, got[i]);
    check("frame_len", 64'(nb), 64'(exp.size()));
    check("frame_bytes", 64'(bad), 64'(0));
    check("fcs_residue", 64'(res), 64'(32'hDEBB20E3));
    check("rd_pulses", 64'(rds), 64'(len));
    check("no_len_error", 64'(errs), 64'(0));
    check("done_pulse", 64'(bus.done), 64'(1));
    check("pkt_cnt", 64'(bus.tx_packet_counter), 64'(4'(c0 + 4'd1)));
    for (int k = 0; k < 12; k++) begin
      if (bus.busy && !bus.control && bus.data == 8'h00 && bus.done == (k == 0)) gap++;
      step();
    end
    check("gap_cycles", 64'(gap), 64'(12));
    check("idle_after_gap", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    vec_t tbl[10];
    int nb, frames, lastrise, run, badper, badlen, badcnt, pre;
    bit er, pc;
    logic [10:0] len;
    int sel;
    tbl = '{'{11'd46, 1'b0, 72}, '{11'd10, 1'b0, 72}, '{11'd1, 1'b0, 72}, '{11'd45, 1'b0, 72},
            '{11'd47, 1'b0, 73}, '{11'd100, 1'b0, 126}, '{11'd1500, 1'b0, 1526},
            '{11'd1501, 1'b1, 0}, '{11'd0, 1'b1, 0}, '{11'd2047, 1'b1, 0}};
    bus.start = 1'b0; bus.dst_addr = '0; bus.src_addr = '0; bus.type_length = '0; bus.payload_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_control", 64'(bus.control), 64'(0));
    check("rst_data", 64'(bus.data), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_len_error", 64'(bus.len_error), 64'(0));
    check("rst_counter", 64'(bus.tx_packet_counter), 64'(0));
    rst = 1'b0;
    step();

    run_frame(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 11'd46, 1'b1, 1'b0, nb, er);
    pre = 0;
    for (int i = 0; i < 7; i++) pre += int'(got[i] == 8'h55);
    check("min_preamble", 64'(pre), 64'(7));
    check("min_sfd", 64'(got[7]), 64'(8'hD5));
    check("min_dst", 64'({got[8], got[9], got[10], got[11], got[12], got[13]}), 64'(48'hFFFFFFFFFFFF));
    check("min_src", 64'({got[14], got[15], got[16], got[17], got[18], got[19]}), 64'(48'h001122334455));
    check("min_counter", 64'(bus.tx_packet_counter), 64'(1));

    foreach (tbl[i]) begin
      run_frame(48'({$urandom, $urandom}), 48'({$urandom, $urandom}), 16'($urandom), tbl[i].len, 1'b0, 1'b0, nb, er);
      check($sformatf("tbl%0d_err", i), 64'(er), 64'(tbl[i].err));
      check($sformatf("tbl%0d_bytes", i), 64'(nb), 64'(tbl[i].nb));
    end

    for (int r = 0; r < 25; r++) begin
      sel = int'($urandom_range(0, 9));
      len = sel == 0 ? 11'd0 : sel == 1 ? 11'($urandom_range(1501, 2047)) :
            sel == 2 ? 11'($urandom_range(1400, 1500)) : 11'($urandom_range(1, 200));
      run_frame(48'({$urandom, $urandom}), 48'({$urandom, $urandom}), 16'($urandom), len, 1'b0, 1'b1, nb, er);
      check($sformatf("rnd%0d_err", r), 64'(er), 64'(!(len != 11'd0 && len <= 11'd1500)));
    end

    for (int i = 0; i < 1500; i++) pay[i] = 8'($urandom);
    pidx = 0; rd_prev = 1'b0;
    bus.payload_len = 11'd100; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (30) step();
    check("mid_frame_ctl", 64'(bus.control), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_control", 64'(bus.control), 64'(0));
    check("mid_rst_data", 64'(bus.data), 64'(0));
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_done", 64'(bus.done), 64'(0));
    check("mid_rst_counter", 64'(bus.tx_packet_counter), 64'(0));
    check("mid_rst_rd", 64'(bus.payload_rd), 64'(0));
    @(negedge clk) rst = 1'b0;
    step();
    run_frame(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h88B5, 11'd60, 1'b0, 1'b0, nb, er);
    check("post_rst_counter", 64'(bus.tx_packet_counter), 64'(1));

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    step();
    pidx = 0; rd_prev = 1'b0;
    bus.payload_len = 11'd46; bus.start = 1'b1;
    frames = 0; lastrise = -1; run = 0; badper = 0; badlen = 0; badcnt = 0; pc = 1'b0;
    for (int cyc = 0; cyc < 1500 && frames < 16; cyc++) begin
      step();
      if (bus.control && !pc) begin
        if (lastrise >= 0 && cyc - lastrise != 85) badper++;
        lastrise = cyc;
      end
      if (bus.control) run++;
      if (!bus.control && pc) begin
        if (run != 72) badlen++;
        run = 0;
      end
      if (bus.done) begin
        frames++;
        if (bus.tx_packet_counter != 4'(frames)) badcnt++;
      end
      pc = bus.control;
    end
    bus.start = 1'b0;
    check("b2b_frames", 64'(frames), 64'(16));
    check("b2b_period", 64'(badper), 64'(0));
    check("b2b_length", 64'(badlen), 64'(0));
    check("b2b_counter_seq", 64'(badcnt), 64'(0));
    check("b2b_wrap", 64'(bus.tx_packet_counter), 64'(0));
    repeat (13) step();
    check("b2b_idle", 64'(bus.busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
